// File: rtl/pixel_pkg.sv
// Shared types and default constants for the pixel dispatcher slice.
package pixel_pkg;

  // Dispatcher control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Default screen geometry and sizing.
  localparam int DEFAULT_SCREEN_WIDTH     = 640;
  localparam int DEFAULT_SCREEN_HEIGHT    = 480;
  localparam int DEFAULT_PIXEL_DATA_WIDTH = 10;
  localparam int DEFAULT_NUM_ENGINES      = 8;
  localparam int DEFAULT_FRAME_CNT_WIDTH  = 16;

  // Width of an engine index; a single engine still gets a 1-bit index.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester found
// when searching upward from the pointer, wrapping at NUM_REQ.
module rr_arbiter
  import pixel_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_ENGINES,
  parameter int IDX_W   = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               grant_valid_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  localparam logic [IDX_W:0] LIMIT = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] cand;

  // Walk candidates ptr, ptr+1, ... (mod NUM_REQ) and keep the first requester.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    cand          = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (cand >= LIMIT) begin
        cand = cand - LIMIT;
      end
      if (!grant_valid_o && req_i[cand[IDX_W-1:0]]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pixel_dispatcher.sv
// Pixel dispatcher: walks the screen in raster order and hands one pixel
// per cycle to a ready engine chosen round-robin; counts finished frames.
module pixel_dispatcher
  import pixel_pkg::*;
#(
  parameter int PIXEL_DATA_WIDTH = DEFAULT_PIXEL_DATA_WIDTH,
  parameter int SCREEN_WIDTH     = DEFAULT_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT    = DEFAULT_SCREEN_HEIGHT,
  parameter int NUM_ENGINES      = DEFAULT_NUM_ENGINES,
  parameter int FRAME_CNT_WIDTH  = DEFAULT_FRAME_CNT_WIDTH,
  localparam int ID_W            = id_width(NUM_ENGINES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        continuous,
  input  logic [NUM_ENGINES-1:0]      eng_ready,
  output logic                        assign_valid,
  output logic [ID_W-1:0]             assign_id,
  output logic [PIXEL_DATA_WIDTH-1:0] assign_x,
  output logic [PIXEL_DATA_WIDTH-1:0] assign_y,
  output logic                        busy,
  output logic                        frame_done,
  output logic [FRAME_CNT_WIDTH-1:0]  frame_count
);

  localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST  = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST  = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);
  localparam logic [ID_W-1:0]             ID_LAST = ID_W'(NUM_ENGINES - 1);

  // Reject geometries the coordinate width cannot represent.
  if (longint'(SCREEN_WIDTH) > (longint'(1) << PIXEL_DATA_WIDTH)) begin : g_width_check
    $error("pixel_dispatcher: SCREEN_WIDTH exceeds 2**PIXEL_DATA_WIDTH");
  end
  if (longint'(SCREEN_HEIGHT) > (longint'(1) << PIXEL_DATA_WIDTH)) begin : g_height_check
    $error("pixel_dispatcher: SCREEN_HEIGHT exceeds 2**PIXEL_DATA_WIDTH");
  end
  if (NUM_ENGINES < 1 || NUM_ENGINES > 32) begin : g_engine_check
    $error("pixel_dispatcher: NUM_ENGINES must be within 1..32");
  end
  if (SCREEN_WIDTH < 1 || SCREEN_HEIGHT < 1) begin : g_screen_check
    $error("pixel_dispatcher: screen dimensions must be positive");
  end

  state_e                      state_q, state_d;
  logic [PIXEL_DATA_WIDTH-1:0] cx_q, cx_d;
  logic [PIXEL_DATA_WIDTH-1:0] cy_q, cy_d;
  logic [ID_W-1:0]             ptr_q, ptr_d;

  logic                        assign_valid_q;
  logic [ID_W-1:0]             assign_id_q;
  logic [PIXEL_DATA_WIDTH-1:0] assign_x_q;
  logic [PIXEL_DATA_WIDTH-1:0] assign_y_q;
  logic                        frame_done_q;
  logic [FRAME_CNT_WIDTH-1:0]  frame_count_q;

  logic [NUM_ENGINES-1:0]      recent_mask;
  logic [NUM_ENGINES-1:0]      arb_req;
  logic                        gnt_valid;
  logic [ID_W-1:0]             gnt_idx;
  logic                        issue;
  logic                        frame_end;

  // Engine whose assign is on the outputs right now still shows ready; hide it.
  always_comb begin
    recent_mask = '0;
    if (assign_valid_q) begin
      recent_mask = NUM_ENGINES'(1) << assign_id_q;
    end
    arb_req = '0;
    if (state_q == RUN) begin
      arb_req = eng_ready & ~recent_mask;
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_ENGINES),
    .IDX_W   (ID_W)
  ) u_rr_arbiter (
    .req_i         (arb_req),
    .ptr_i         (ptr_q),
    .grant_valid_o (gnt_valid),
    .grant_idx_o   (gnt_idx)
  );

  // Next-state logic: frame sequencing, raster cursor and arbitration pointer.
  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    ptr_d     = ptr_q;
    issue     = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cx_d    = '0;
          cy_d    = '0;
        end
      end
      RUN: begin
        if (gnt_valid) begin
          issue = 1'b1;
          ptr_d = (gnt_idx == ID_LAST) ? '0 : gnt_idx + 1'b1;
          if (cx_q == X_LAST) begin
            cx_d = '0;
            if (cy_q == Y_LAST) begin
              cy_d    = '0;
              state_d = DRAIN;
            end else begin
              cy_d = cy_q + 1'b1;
            end
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (&eng_ready) begin
          frame_end = 1'b1;
          cx_d      = '0;
          cy_d      = '0;
          state_d   = continuous ? RUN : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cx_d    = '0;
        cy_d    = '0;
      end
    endcase
  end

  // Control state, cursor and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ptr_q   <= ptr_d;
    end
  end

  // Registered assign outputs; payload is only reloaded on an actual grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      assign_valid_q <= 1'b0;
      assign_id_q    <= '0;
      assign_x_q     <= '0;
      assign_y_q     <= '0;
    end else begin
      assign_valid_q <= issue;
      if (issue) begin
        assign_id_q <= gnt_idx;
        assign_x_q  <= cx_q;
        assign_y_q  <= cy_q;
      end
    end
  end

  // Frame completion pulse and wrapping frame counter, updated together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= frame_end;
      if (frame_end) begin
        frame_count_q <= frame_count_q + 1'b1;
      end
    end
  end

  assign assign_valid = assign_valid_q;
  assign assign_id    = assign_id_q;
  assign assign_x     = assign_x_q;
  assign assign_y     = assign_y_q;
  assign busy         = (state_q != IDLE);
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Self-checking bench for pixel_dispatcher on a 4x2 screen with 2 engines.
module tb_pixel_dispatcher;

  localparam int PW = 4;
  localparam int SW = 4;
  localparam int SH = 2;
  localparam int NE = 2;
  localparam int FW = 4;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic [NE-1:0] engReady = '0;
  logic          assignValid;
  logic [IW-1:0] assignId;
  logic [PW-1:0] assignX;
  logic [PW-1:0] assignY;
  logic          busy;
  logic          frameDone;
  logic [FW-1:0] frameCount;

  int checks = 0;
  int errors = 0;

  // Reference model state: frame phase in words, pixels issued so far.
  int  mPhase;      // 0 waiting for start, 1 issuing, 2 waiting for engines
  int  mIdx;
  int  mPtr;
  bit  mLastValid;
  int  mLastId;
  int  mFrames;
  bit  expValid;
  int  expId;
  int  expX;
  int  expY;
  bit  expDone;
  bit  seen[SW*SH];
  int  seenCount;

  typedef struct {
    bit          st;
    bit          co;
    logic [1:0]  rdy;
    bit          eValid;
    int          eId;
    int          eX;
    int          eY;
    bit          eDone;
    bit          eBusy;
    int          eCount;
  } vecT;

  vecT vecs[11];

  always #5 clk = ~clk;

  pixel_dispatcher #(
    .PIXEL_DATA_WIDTH (PW),
    .SCREEN_WIDTH     (SW),
    .SCREEN_HEIGHT    (SH),
    .NUM_ENGINES      (NE),
    .FRAME_CNT_WIDTH  (FW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .continuous   (continuous),
    .eng_ready    (engReady),
    .assign_valid (assignValid),
    .assign_id    (assignId),
    .assign_x     (assignX),
    .assign_y     (assignY),
    .busy         (busy),
    .frame_done   (frameDone),
    .frame_count  (frameCount)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic clearSeen();
    for (int i = 0; i < SW*SH; i++) seen[i] = 1'b0;
    seenCount = 0;
  endtask

  task automatic modelReset();
    mPhase = 0; mIdx = 0; mPtr = 0; mLastValid = 1'b0; mLastId = 0; mFrames = 0;
    expValid = 1'b0; expId = 0; expX = 0; expY = 0; expDone = 1'b0;
    clearSeen();
  endtask

  // Predict what the outputs show after one clock with the given inputs.
  task automatic modelStep(input bit st, input bit co, input logic [NE-1:0] rdy);
    logic [NE-1:0] elig;
    int pick;
    expValid = 1'b0;
    expDone  = 1'b0;
    case (mPhase)
      0: if (st) begin mPhase = 1; mIdx = 0; end
      1: begin
        elig = rdy;
        if (mLastValid) elig[mLastId] = 1'b0;
        pick = -1;
        for (int i = 0; i < NE; i++) begin
          if (pick < 0 && elig[(mPtr + i) % NE]) pick = (mPtr + i) % NE;
        end
        if (pick >= 0) begin
          expValid = 1'b1;
          expId = pick;
          expX = mIdx % SW;
          expY = mIdx / SW;
          mPtr = (pick + 1) % NE;
          mIdx++;
          if (mIdx == SW*SH) mPhase = 2;
        end
      end
      default: if (&rdy) begin
        expDone = 1'b1;
        mFrames = (mFrames + 1) % (1 << FW);
        mIdx = 0;
        mPhase = co ? 1 : 0;
      end
    endcase
    mLastValid = expValid;
    if (expValid) mLastId = expId;
  endtask

  // Drive one cycle of inputs, then compare against the model and scoreboard.
  task automatic applyStimulus(input bit st, input bit co, input logic [NE-1:0] rdy);
    int pix;
    start = st; continuous = co; engReady = rdy;
    @(posedge clk);
    @(negedge clk);
    modelStep(st, co, rdy);
    checkOutput("valid", assignValid, expValid);
    if (expValid) begin
      checkOutput("id", assignId, expId);
      checkOutput("x", assignX, expX);
      checkOutput("y", assignY, expY);
    end
    checkOutput("frameDone", frameDone, expDone);
    checkOutput("frameCount", frameCount, mFrames);
    checkOutput("busy", busy, (mPhase != 0) ? 1 : 0);
    if (assignValid === 1'b1) begin
      pix = int'(assignY) * SW + int'(assignX);
      if (pix >= SW*SH) begin
        checkOutput("pixelInRange", pix, 0);
      end else begin
        checkOutput("duplicatePixel", seen[pix], 0);
        seen[pix] = 1'b1;
        seenCount++;
      end
    end
    if (frameDone === 1'b1) begin
      checkOutput("frameCoverage", seenCount, SW*SH);
      clearSeen();
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int baseCount;
    int dones;
    bit firstPending;
    bit hit;
    bit co;
    logic [NE-1:0] rdy;

    modelReset();
    vecs[0]  = '{1, 0, 2'b11, 0, 0, 0, 0, 0, 1, 0};
    vecs[1]  = '{0, 0, 2'b11, 1, 0, 0, 0, 0, 1, 0};
    vecs[2]  = '{0, 0, 2'b11, 1, 1, 1, 0, 0, 1, 0};
    vecs[3]  = '{0, 0, 2'b11, 1, 0, 2, 0, 0, 1, 0};
    vecs[4]  = '{0, 0, 2'b11, 1, 1, 3, 0, 0, 1, 0};
    vecs[5]  = '{0, 0, 2'b11, 1, 0, 0, 1, 0, 1, 0};
    vecs[6]  = '{0, 0, 2'b11, 1, 1, 1, 1, 0, 1, 0};
    vecs[7]  = '{0, 0, 2'b11, 1, 0, 2, 1, 0, 1, 0};
    vecs[8]  = '{0, 0, 2'b11, 1, 1, 3, 1, 0, 1, 0};
    vecs[9]  = '{0, 0, 2'b11, 0, 0, 0, 0, 1, 0, 1};
    vecs[10] = '{0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 1};

    // Reset values.
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstValid", assignValid, 0);
    checkOutput("rstId", assignId, 0);
    checkOutput("rstX", assignX, 0);
    checkOutput("rstY", assignY, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", frameDone, 0);
    checkOutput("rstCount", frameCount, 0);
    reset = 1'b1;

    // Single frame, both engines always ready.
    $display("[TB] raster table, 2 engines always ready");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].st, vecs[i].co, vecs[i].rdy);
      checkOutput("tblValid", assignValid, vecs[i].eValid);
      if (vecs[i].eValid) begin
        checkOutput("tblId", assignId, vecs[i].eId);
        checkOutput("tblX", assignX, vecs[i].eX);
        checkOutput("tblY", assignY, vecs[i].eY);
      end
      checkOutput("tblDone", frameDone, vecs[i].eDone);
      checkOutput("tblBusy", busy, vecs[i].eBusy);
      checkOutput("tblCount", frameCount, vecs[i].eCount);
    end

    // No ready engine for 5 cycles mid-frame: cursor must hold.
    $display("[TB] stall mid-frame");
    applyStimulus(1, 0, 2'b11);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 2'b11);
    checkOutput("preStallX", assignX, 2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 2'b00);
      checkOutput("stallValid", assignValid, 0);
    end
    applyStimulus(0, 0, 2'b11);
    checkOutput("resumeValid", assignValid, 1);
    checkOutput("resumeX", assignX, 3);
    checkOutput("resumeY", assignY, 0);
    hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      applyStimulus(0, 0, 2'b11);
      hit = (frameDone === 1'b1);
    end
    checkOutput("stallFrameDone", hit, 1);

    // Continuous mode over three frames.
    $display("[TB] continuous, three frames");
    baseCount = mFrames;
    dones = 0;
    firstPending = 1'b1;
    applyStimulus(1, 1, 2'b11);
    for (int n = 0; n < 100 && dones < 3; n++) begin
      co = (dones < 2);
      applyStimulus(0, co, 2'b11);
      if (assignValid === 1'b1 && firstPending) begin
        checkOutput("frameStartX", assignX, 0);
        checkOutput("frameStartY", assignY, 0);
        firstPending = 1'b0;
      end
      if (frameDone === 1'b1) begin
        dones++;
        checkOutput("contCount", frameCount, (baseCount + dones) % (1 << FW));
        firstPending = 1'b1;
        if (dones == 3) checkOutput("contStopsBusy", busy, 0);
      end
    end
    checkOutput("contFrames", dones, 3);

    // Engine 1 holds off the end of frame while draining.
    $display("[TB] drain held by engine 1");
    applyStimulus(1, 0, 2'b11);
    for (int n = 0; n < 20 && mPhase != 2; n++) applyStimulus(0, 0, 2'b11);
    checkOutput("reachedDrain", mPhase, 2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 2'b01);
      checkOutput("drainHeldDone", frameDone, 0);
      checkOutput("drainHeldBusy", busy, 1);
    end
    applyStimulus(0, 0, 2'b11);
    checkOutput("drainReleaseDone", frameDone, 1);

    // Asynchronous reset while issuing pixel (2,1).
    $display("[TB] reset mid-frame");
    applyStimulus(1, 0, 2'b11);
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      applyStimulus(0, 0, 2'b11);
      hit = (assignValid === 1'b1 && assignX == 2 && assignY == 1);
    end
    checkOutput("reachedPixel21", hit, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("midRstValid", assignValid, 0);
    checkOutput("midRstId", assignId, 0);
    checkOutput("midRstX", assignX, 0);
    checkOutput("midRstY", assignY, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstDone", frameDone, 0);
    checkOutput("midRstCount", frameCount, 0);
    modelReset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("inRstDone", frameDone, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 2'b11);
      checkOutput("postRstIdle", busy, 0);
      checkOutput("postRstNoDone", frameDone, 0);
    end
    applyStimulus(1, 0, 2'b11);
    applyStimulus(0, 0, 2'b11);
    checkOutput("restartValid", assignValid, 1);
    checkOutput("restartId", assignId, 0);
    checkOutput("restartX", assignX, 0);
    checkOutput("restartY", assignY, 0);

    // Random readiness, start and continuous against the model.
    $display("[TB] random traffic");
    for (int n = 0; n < 1500; n++) begin
      rdy = '0;
      for (int b = 0; b < NE; b++) rdy[b] = ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
